// File: rtl/sha3_absorb_buffer_if.sv
// sha3_absorb_buffer_if
//   Bundles the two streams around the SHA3-256 absorb buffer.
//   Word stream (message in): in_valid, in_ready, in_data[63:0], in_last, in_bytes[3:0]
//   Block stream (rate block out): block_valid, block_ready, block_data[1087:0],
//                                  block_first, block_last
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both 1. Once valid is raised it stays high, and its
// payload stays constant, until that transfer happens. Ready may be raised or
// lowered at any time and may be held high constantly.
//
// Modports:
//   slave  - the absorb buffer itself (sinks words, sources blocks)
//   master - the environment around it (sources words, sinks blocks)
interface sha3_absorb_buffer_if;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          block_valid;
    logic          block_ready;
    logic [1087:0] block_data;
    logic          block_first;
    logic          block_last;

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, block_ready,
        output in_ready, block_valid, block_data, block_first, block_last
    );

    modport master (
        output in_valid, in_data, in_last, in_bytes, block_ready,
        input  in_ready, block_valid, block_data, block_first, block_last
    );
endinterface

// File: rtl/sha3_absorb_buffer.sv
// sha3_absorb_buffer
//   Packs a little-endian 64-bit word stream into 1088-bit SHA3-256 rate
//   blocks (17 words), applies the 0x06 ... 0x80 domain padding to the final
//   block and hands each block to the absorb XOR stage with first/last flags.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of sha3_absorb_buffer_if (word in, block out)
//   dbg_state  out  current FSM state: 0 = ACCUM, 1 = EMIT, 2 = EXTRA
module sha3_absorb_buffer (
    input  logic                       clk,
    input  logic                       rst_n,
    sha3_absorb_buffer_if.slave        bus,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        EMIT  = 2'd1,
        EXTRA = 2'd2
    } state_t;

    // Padding-only block: used when the message exactly fills a rate block.
    localparam logic [1087:0] EXTRA_BLK = {8'h80, 1072'd0, 8'h06};

    state_t        state;
    logic [4:0]    word_cnt;     // next free word slot, 0..16
    logic [1087:0] blk_q;        // assembly buffer, doubles as block_data
    logic          valid_q;
    logic          first_q;
    logic          last_q;
    logic          extra_pend;   // a padding-only block must follow this one
    logic          first_pend;   // next emitted block starts a new message

    // Combinational view of the buffer with the current word merged in.
    logic [3:0]    bytes_eff;
    logic [7:0]    pad_pos;
    logic          pad_here;
    logic          last_full;
    logic [1087:0] packed_blk;

    always_comb begin
        bytes_eff  = (bus.in_bytes > 4'd8) ? 4'd8 : bus.in_bytes;
        pad_pos    = {word_cnt, 3'b000} + {4'b0000, bytes_eff};
        pad_here   = bus.in_last && (pad_pos <= 8'd135);
        last_full  = bus.in_last && (pad_pos == 8'd136);
        packed_blk = '0;
        for (int b = 0; b < 136; b++) begin
            if (5'(b / 8) < word_cnt) begin
                packed_blk[8*b +: 8] = blk_q[8*b +: 8];
            end else if (5'(b / 8) == word_cnt) begin
                // Bytes past the message end in the final word are dropped.
                if (!bus.in_last || (4'(b % 8) < bytes_eff)) begin
                    packed_blk[8*b +: 8] = bus.in_data[8*(b % 8) +: 8];
                end
            end
            if (pad_here && (8'(b) == pad_pos)) begin
                packed_blk[8*b +: 8] = 8'h06;
            end
        end
        // OR-ing bit 7 of byte 135 turns a 0x06 there into 0x86.
        if (pad_here) begin
            packed_blk[1087] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            word_cnt   <= '0;
            blk_q      <= '0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            extra_pend <= 1'b0;
            first_pend <= 1'b1;
        end else begin
            unique case (state)
                ACCUM: begin
                    // in_ready is 1 throughout ACCUM, so in_valid is a transfer.
                    if (bus.in_valid) begin
                        blk_q <= packed_blk;
                        if (bus.in_last || (word_cnt == 5'd16)) begin
                            word_cnt   <= '0;
                            valid_q    <= 1'b1;
                            first_q    <= first_pend;
                            last_q     <= bus.in_last && !last_full;
                            extra_pend <= last_full;
                            state      <= EMIT;
                        end else begin
                            word_cnt <= word_cnt + 5'd1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.block_ready) begin
                        // Only a final block re-arms first; any other clears it.
                        first_pend <= last_q;
                        if (extra_pend) begin
                            blk_q   <= EXTRA_BLK;
                            first_q <= 1'b0;
                            last_q  <= 1'b1;
                            state   <= EXTRA;
                        end else begin
                            blk_q   <= '0;
                            valid_q <= 1'b0;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                            state   <= ACCUM;
                        end
                    end
                end
                EXTRA: begin
                    if (bus.block_ready) begin
                        extra_pend <= 1'b0;
                        first_pend <= 1'b1;
                        blk_q      <= '0;
                        valid_q    <= 1'b0;
                        first_q    <= 1'b0;
                        last_q     <= 1'b0;
                        state      <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // While block_valid is low, block_data shows the partially filled buffer.
    assign bus.in_ready    = (state == ACCUM);
    assign bus.block_valid = valid_q;
    assign bus.block_data  = blk_q;
    assign bus.block_first = first_q;
    assign bus.block_last  = last_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_sha3_absorb_buffer.sv
// tb_sha3_absorb_buffer
//   Directed bench for sha3_absorb_buffer: reset values, empty / "abc" /
//   135-byte / 136-byte messages, a two-block message, in_bytes clamping,
//   block backpressure and reset in the middle of a message.
module tb_sha3_absorb_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         errors = 0;
    int         checks = 0;

    sha3_absorb_buffer_if bus ();

    sha3_absorb_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- helpers
    function automatic logic [7:0] msg_byte(int b, int seed);
        return 8'(b * 7 + seed * 13 + 1);
    endfunction

    function automatic logic [63:0] make_word(int i, int seed);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = msg_byte(8 * i + j, seed);
        return w;
    endfunction

    // Block holding message bytes [offset, offset+nbytes), optionally padded.
    function automatic logic [1087:0] pad_block(int nbytes, int seed, int offset, bit pad);
        logic [1087:0] e;
        e = '0;
        for (int b = 0; b < nbytes; b++) e[8*b +: 8] = msg_byte(offset + b, seed);
        if (pad) begin
            e[8*nbytes +: 8] = 8'h06;
            e[1087:1080]     = e[1087:1080] | 8'h80;
        end
        return e;
    endfunction

    function automatic logic [1087:0] abc_block();
        logic [1087:0] e;
        e            = '0;
        e[7:0]       = 8'h61;
        e[15:8]      = 8'h62;
        e[23:16]     = 8'h63;
        e[31:24]     = 8'h06;
        e[1087:1080] = 8'h80;
        return e;
    endfunction

    function automatic int first_diff(logic [1087:0] a, logic [1087:0] b);
        for (int i = 0; i < 136; i++) if (a[8*i +: 8] !== b[8*i +: 8]) return i;
        return 0;
    endfunction

    // --------------------------------------------------------- driver tasks
    // Both tasks start and end 1 time unit after a rising edge.
    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_bytes = nb;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            checks++; errors++;
            $display("FAIL send_word_timeout in_ready got %b exp 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_bytes = 4'd0;
    endtask

    // Takes one block; g = negedges waited after the first one.
    task automatic get_block(output logic [1087:0] d, output logic f, output logic l, output int g);
        g = 0;
        bus.block_ready = 1'b1;
        @(negedge clk);
        while (bus.block_valid !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            checks++; errors++;
            $display("FAIL get_block_timeout block_valid got %b exp 1", bus.block_valid);
        end
        d = bus.block_data;
        f = bus.block_first;
        l = bus.block_last;
        @(posedge clk); #1;
        bus.block_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.in_bytes    = 4'd0;
        bus.block_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.block_valid); end
        checks++; if (bus.block_data !== '0) begin errors++; $display("FAIL reset_data got nonzero exp 0"); end
        checks++; if (bus.block_first !== 1'b0) begin errors++; $display("FAIL reset_first got %b exp 0", bus.block_first); end
        checks++; if (bus.block_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", bus.block_last); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        logic [1087:0] d, e;
        logic f, l;
        int g, i;
        e = '0;
        e[7:0] = 8'h06;
        e[1087:1080] = 8'h80;
        send_word(64'h0, 1'b1, 4'd0);
        get_block(d, f, l, g);
        checks++; if (g !== 0) begin errors++; $display("FAIL empty_latency got %0d extra cycles exp 0", g); end
        checks++; if (d !== e) begin errors++; i = first_diff(d, e); $display("FAIL empty_data byte %0d got %02h exp %02h", i, d[8*i +: 8], e[8*i +: 8]); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL empty_first got %b exp 1", f); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL empty_last got %b exp 1", l); end
    endtask

    task automatic test_abc();
        logic [1087:0] d, e;
        logic f, l;
        int g, i;
        e = abc_block();
        send_word(64'h0000000000636261, 1'b1, 4'd3);
        get_block(d, f, l, g);
        checks++; if (d !== e) begin errors++; i = first_diff(d, e); $display("FAIL abc_data byte %0d got %02h exp %02h", i, d[8*i +: 8], e[8*i +: 8]); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL abc_first got %b exp 1", f); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL abc_last got %b exp 1", l); end
    endtask

    task automatic test_135();
        logic [1087:0] d, e;
        logic f, l;
        int g, i;
        e = pad_block(135, 3, 0, 1'b1);
        for (int w = 0; w < 16; w++) send_word(make_word(w, 3), 1'b0, 4'd0);
        send_word(make_word(16, 3), 1'b1, 4'd7);
        get_block(d, f, l, g);
        checks++; if (d[1087:1080] !== 8'h86) begin errors++; $display("FAIL m135_byte135 got %02h exp 86", d[1087:1080]); end
        checks++; if (d !== e) begin errors++; i = first_diff(d, e); $display("FAIL m135_data byte %0d got %02h exp %02h", i, d[8*i +: 8], e[8*i +: 8]); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL m135_first got %b exp 1", f); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL m135_last got %b exp 1", l); end
    endtask

    task automatic test_136();
        logic [1087:0] d, e, x;
        logic f, l;
        int g, i;
        e = pad_block(136, 7, 0, 1'b0);
        x = '0;
        x[7:0] = 8'h06;
        x[1087:1080] = 8'h80;
        for (int w = 0; w < 16; w++) send_word(make_word(w, 7), 1'b0, 4'd0);
        send_word(make_word(16, 7), 1'b1, 4'd8);
        get_block(d, f, l, g);
        checks++; if (d !== e) begin errors++; i = first_diff(d, e); $display("FAIL m136_a_data byte %0d got %02h exp %02h", i, d[8*i +: 8], e[8*i +: 8]); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL m136_a_first got %b exp 1", f); end
        checks++; if (l !== 1'b0) begin errors++; $display("FAIL m136_a_last got %b exp 0", l); end
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL m136_extra_state got %0d exp 2", dbg_state); end
        get_block(d, f, l, g);
        checks++; if (g !== 0) begin errors++; $display("FAIL m136_b_latency got %0d extra cycles exp 0", g); end
        checks++; if (d !== x) begin errors++; i = first_diff(d, x); $display("FAIL m136_b_data byte %0d got %02h exp %02h", i, d[8*i +: 8], x[8*i +: 8]); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL m136_b_first got %b exp 0", f); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL m136_b_last got %b exp 1", l); end
    endtask

    // in_bytes above 8 on a last word behaves like 8; first re-armed after EXTRA.
    task automatic test_bytes_clamp();
        logic [1087:0] d, e;
        logic f, l;
        int g, i;
        e = pad_block(16, 9, 0, 1'b1);
        send_word(make_word(0, 9), 1'b0, 4'd2);
        send_word(make_word(1, 9), 1'b1, 4'd12);
        get_block(d, f, l, g);
        checks++; if (d !== e) begin errors++; i = first_diff(d, e); $display("FAIL clamp_data byte %0d got %02h exp %02h", i, d[8*i +: 8], e[8*i +: 8]); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL clamp_first got %b exp 1", f); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL clamp_last got %b exp 1", l); end
    endtask

    // 154-byte message: one full block, then 18 bytes padded into a second.
    task automatic test_back_to_back();
        logic [1087:0] d, e;
        logic f, l;
        int g, i;
        for (int w = 0; w < 17; w++) send_word(make_word(w, 11), 1'b0, 4'd0);
        get_block(d, f, l, g);
        e = pad_block(136, 11, 0, 1'b0);
        checks++; if (d !== e) begin errors++; i = first_diff(d, e); $display("FAIL b2b_a_data byte %0d got %02h exp %02h", i, d[8*i +: 8], e[8*i +: 8]); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL b2b_a_first got %b exp 1", f); end
        checks++; if (l !== 1'b0) begin errors++; $display("FAIL b2b_a_last got %b exp 0", l); end
        send_word(make_word(17, 11), 1'b0, 4'd0);
        send_word(make_word(18, 11), 1'b0, 4'd0);
        send_word(make_word(19, 11), 1'b1, 4'd2);
        get_block(d, f, l, g);
        e = pad_block(18, 11, 136, 1'b1);
        checks++; if (d !== e) begin errors++; i = first_diff(d, e); $display("FAIL b2b_b_data byte %0d got %02h exp %02h", i, d[8*i +: 8], e[8*i +: 8]); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL b2b_b_first got %b exp 0", f); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL b2b_b_last got %b exp 1", l); end
    endtask

    task automatic test_backpressure();
        logic [1087:0] d, e, a;
        logic f, l;
        int g, i;
        e = pad_block(136, 5, 0, 1'b0);
        a = abc_block();
        for (int w = 0; w < 17; w++) send_word(make_word(w, 5), 1'b0, 4'd0);
        bus.block_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 64'hDEAD_BEEF_0000_0000 | 64'(k);
            bus.in_last  = (k == 2);
            bus.in_bytes = 4'd3;
            @(negedge clk);
            checks++; if (bus.block_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b exp 1", k, bus.block_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b exp 0", k, bus.in_ready); end
            checks++; if (bus.block_data !== e) begin errors++; i = first_diff(bus.block_data, e); $display("FAIL bp_data cycle %0d byte %0d got %02h exp %02h", k, i, bus.block_data[8*i +: 8], e[8*i +: 8]); end
            checks++; if (bus.block_first !== 1'b1) begin errors++; $display("FAIL bp_first cycle %0d got %b exp 1", k, bus.block_first); end
            checks++; if (bus.block_last !== 1'b0) begin errors++; $display("FAIL bp_last cycle %0d got %b exp 0", k, bus.block_last); end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        get_block(d, f, l, g);
        checks++; if (d !== e) begin errors++; i = first_diff(d, e); $display("FAIL bp_taken_data byte %0d got %02h exp %02h", i, d[8*i +: 8], e[8*i +: 8]); end
        send_word(64'h0000000000636261, 1'b1, 4'd3);
        get_block(d, f, l, g);
        checks++; if (d !== a) begin errors++; i = first_diff(d, a); $display("FAIL bp_next_data byte %0d got %02h exp %02h", i, d[8*i +: 8], a[8*i +: 8]); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL bp_next_first got %b exp 0", f); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL bp_next_last got %b exp 1", l); end
    endtask

    task automatic test_reset_mid();
        logic [1087:0] d, a;
        logic f, l;
        int g, i;
        a = abc_block();
        for (int w = 0; w < 5; w++) send_word(make_word(w, 13), 1'b0, 4'd0);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", bus.block_valid); end
        checks++; if (bus.block_data !== '0) begin errors++; $display("FAIL rmid_data got nonzero exp 0"); end
        checks++; if (bus.block_first !== 1'b0) begin errors++; $display("FAIL rmid_first got %b exp 0", bus.block_first); end
        checks++; if (bus.block_last !== 1'b0) begin errors++; $display("FAIL rmid_last got %b exp 0", bus.block_last); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rmid_state got %0d exp 0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(64'h0000000000636261, 1'b1, 4'd3);
        get_block(d, f, l, g);
        checks++; if (d !== a) begin errors++; i = first_diff(d, a); $display("FAIL rmid_abc_data byte %0d got %02h exp %02h", i, d[8*i +: 8], a[8*i +: 8]); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL rmid_abc_first got %b exp 1", f); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL rmid_abc_last got %b exp 1", l); end
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_135();
        test_136();
        test_bytes_clamp();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha3_absorb_buffer.md
# sha3_absorb_buffer

Upstream feeder for the SHA3-256 absorb XOR stage. Accepts a message as a stream of 64-bit little-endian words with a valid/ready handshake. Packs the words into 1088-bit rate blocks (17 words), applies SHA3 domain padding (0x06 … 0x80) to the final block, and presents each block with first/last flags over a valid/ready handshake. The block data drives the rate-block input of the absorb XOR stage. `block_first` tells the consumer to start from a zero state.

## Interface
- No parameters; rate fixed at 1088 bits (136 bytes, 17 words).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  64  message word; byte k at bits [8k+7:8k].
- `in_last`  in  1  word is the final word of the message.
- `in_bytes`  in  4  valid bytes in the final word, 0..8; values >8 are treated as 8; ignored unless `in_last`.
- `block_valid`  out  1  rate block available.
- `block_ready`  in  1  consumer takes the block.
- `block_data`  out  1088  rate block; word i at bits [64i+63:64i], byte b at bits [8b+7:8b].
- `block_first`  out  1  block is the first of its message.
- `block_last`  out  1  block is the final, padded block of its message.

## Operation
- States:
  - ACCUM: collecting words.
  - EMIT: holding a block.
  - EXTRA: holding the padding-only block.
- Internals:
  - `word_cnt`, 0..16.
  - `first_pend`, set at reset and after each `block_last` handshake.
  - `extra_pend`.
- ACCUM: `in_ready`=1. On `in_valid && in_ready`, store `in_data` into word slot `word_cnt` and increment `word_cnt`.
  - Non-final word, `word_cnt`==16: go to EMIT with `block_last`=0 and `word_cnt` reset to 0.
  - Final word: let p = 8*`word_cnt` + `in_bytes`.
    - Bytes of the last word at positions ≥ `in_bytes` are zeroed.
    - All later bytes of the block are zeroed.
    - If p ≤ 135: byte p = 0x06 and byte 135 |= 0x80 (p=135 gives 0x86). Go to EMIT with `block_last`=1.
    - If p = 136 (word 16 full): the block goes out unpadded with `block_last`=0, `extra_pend`=1, then EMIT.
- EMIT: `in_ready`=0; `block_valid`=1 and all outputs held stable.
  - On `block_valid && block_ready`: go to EXTRA if `extra_pend`, else go to ACCUM with the buffer cleared to zero.
- EXTRA: `block_data` has byte 0 = 0x06, byte 135 = 0x80, all other bytes zero; `block_first`=0, `block_last`=1.
  - On handshake: clear `extra_pend`, set `first_pend`, go to ACCUM.
- `block_first` = `first_pend` latched at EMIT entry. `first_pend` clears on the first block handshake of a message.
- Empty message (`in_last` with `in_bytes`=0 at `word_cnt`=0): one block, byte0=0x06, byte135=0x80, first=1, last=1.
- `in_valid` while `in_ready`=0 is ignored; no word is lost or duplicated.

## Timing
- Reset values: state=ACCUM, `word_cnt`=0, buffer=0, `block_valid`=0, `block_data`=0, `block_first`=0, `block_last`=0, `extra_pend`=0, `first_pend`=1.
- `in_ready` comes from state only. It is 1 from the first cycle after reset release.
- All outputs are registered.
- `block_valid` rises the cycle after the handshake of the 17th or final word.
- Throughput: one word per cycle in ACCUM. At least 1 cycle in EMIT per block, so at best 18 cycles per full block.
- `block_ready` may be held high constantly; the block then leaves after exactly 1 EMIT cycle.
- Backpressure: while `block_ready`=0, `block_valid` and `block_data`/`block_first`/`block_last` stay constant.
- Reset asserted mid-message or mid-EMIT: the partial block is discarded and all state returns to reset values immediately. The next message starts with `block_first`=1.

## Test plan
- Empty message: `in_last`=1, `in_bytes`=0 → one block with byte0=0x06, byte135=0x80, rest 0; first=1, last=1; `block_valid` rises 1 cycle after the accept.
- "abc": `in_data`=0x0000000000636261, `in_bytes`=3, last → bytes0..2=61 62 63, byte3=0x06, byte135=0x80, rest 0; first=last=1.
- 135-byte message: 16 full words plus last word with `in_bytes`=7 → single block, byte135=0x86, first=last=1.
- 136-byte message: 17 full words, last word `in_bytes`=8 → block A unpadded (first=1, last=0), then EXTRA block (byte0=0x06, byte135=0x80, first=0, last=1).
- Backpressure: `block_ready`=0 for 5 cycles with `in_valid`=1 and changing data → `block_valid`, data and flags stable, `in_ready`=0, no word consumed. The next word after the handshake lands in slot 0.
- Reset mid-message: 5 words accepted, then `rst_n` pulsed low → all outputs 0. Then a 3-byte message yields a single block identical to the "abc" case with first=1.
